// File: rtl/ysyx_22040895_bru.sv
// -----------------------------------------------------------------------------
// ysyx_22040895_bru -- branch resolution unit
//
// Resolves conditional branches in EX: compares the two full-width operands
// (signed and unsigned), computes the branch target pc + (offset << 1), and
// registers the outcome with one cycle of latency.  A direct-mapped bimodal
// history table of 2-bit saturating counters gives a combinational prediction
// to fetch and is trained by every accepted branch.  Two saturating counters
// track resolved branches and mispredictions.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   valid_i           branch instruction present in EX
//   flush_i           kill the EX instruction (wins over valid_i)
//   bcuop_i           001 beq, 010 bge, 011 bgeu, 100 blt, 101 bltu, 110 bne
//                     000/111 are not branches and are ignored
//   src1_i, src2_i    rs1 / rs2 values
//   pc_i              PC of the branch in EX
//   offset_i          sign-extended imm[12:1]
//   pred_taken_i      prediction made at fetch for this branch
//   fetch_pc_i        PC being fetched, used for the table lookup
//   fetch_pred_o      predicted taken for fetch_pc_i (table state before any
//                     same-cycle update)
//   res_valid_o       registered resolution valid
//   res_taken_o       actual outcome (holds when no resolution)
//   res_mispredict_o  outcome differs from pred_taken_i
//   res_redirect_o    correct next PC (holds when no resolution)
//   br_cnt_o          resolved branch count, saturating
//   mis_cnt_o         mispredict count, saturating
// -----------------------------------------------------------------------------
module ysyx_22040895_bru #(
    parameter int XLEN      = 64,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [2:0]       bcuop_i,
    input  logic [XLEN-1:0]  src1_i,
    input  logic [XLEN-1:0]  src2_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  offset_i,
    input  logic             pred_taken_i,
    input  logic [XLEN-1:0]  fetch_pc_i,
    output logic             fetch_pred_o,
    output logic             res_valid_o,
    output logic             res_taken_o,
    output logic             res_mispredict_o,
    output logic [XLEN-1:0]  res_redirect_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mis_cnt_o
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_BEQ  = 3'b001,
        OP_BGE  = 3'b010,
        OP_BGEU = 3'b011,
        OP_BLT  = 3'b100,
        OP_BLTU = 3'b101,
        OP_BNE  = 3'b110,
        OP_RSVD = 3'b111
    } bcu_op_e;

    // 2-bit counter encodings
    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    // -------------------------------------------------------------------------
    // Table indexing: instructions are word aligned, so bits [1:0] are skipped.
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             addr_bits_unused;

    assign fetch_idx = fetch_pc_i[IDX_W+1:2];
    assign ex_idx    = pc_i[IDX_W+1:2];

    // Upper fetch PC bits and the low alignment bits do not take part in the
    // lookup; fold them into a sink so the intent is explicit.
    assign addr_bits_unused = ^{fetch_pc_i[XLEN-1:IDX_W+2], fetch_pc_i[1:0]};

    // -------------------------------------------------------------------------
    // Bimodal history table.  Kept in flops rather than block RAM because
    // fetch needs a same-cycle read and reset must initialise every entry.
    // -------------------------------------------------------------------------
    logic [1:0]           bht_reg [BHT_DEPTH];
    logic [BHT_DEPTH-1:0] entry_we;
    logic [1:0]           ctr_cur;
    logic [1:0]           ctr_next;

    // Prediction reads the registered table, so an update landing at the end
    // of this cycle is only visible from the next cycle on.
    assign fetch_pred_o = bht_reg[fetch_idx][1];
    assign ctr_cur      = bht_reg[ex_idx];

    // -------------------------------------------------------------------------
    // Compare and decode
    // -------------------------------------------------------------------------
    bcu_op_e   op;
    logic      eq;
    logic      lt;
    logic      ltu;
    logic      op_legal;
    logic      taken;
    logic      accept;

    assign op  = bcu_op_e'(bcuop_i);
    assign eq  = (src1_i == src2_i);
    assign lt  = ($signed(src1_i) < $signed(src2_i));
    assign ltu = (src1_i < src2_i);

    always_comb begin
        op_legal = 1'b0;
        taken    = 1'b0;
        case (op)
            OP_BEQ:  begin op_legal = 1'b1; taken = eq;   end
            OP_BGE:  begin op_legal = 1'b1; taken = ~lt;  end
            OP_BGEU: begin op_legal = 1'b1; taken = ~ltu; end
            OP_BLT:  begin op_legal = 1'b1; taken = lt;   end
            OP_BLTU: begin op_legal = 1'b1; taken = ltu;  end
            OP_BNE:  begin op_legal = 1'b1; taken = ~eq;  end
            default: begin op_legal = 1'b0; taken = 1'b0; end
        endcase
    end

    // Flush wins over valid; reserved encodings never reach any state.
    assign accept = valid_i & ~flush_i & op_legal;

    // -------------------------------------------------------------------------
    // Target / fall-through.  Both wrap modulo 2^XLEN silently.
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] redirect_next;

    assign target        = pc_i + {offset_i[XLEN-2:0], 1'b0};
    assign seq_pc        = pc_i + XLEN'(4);
    assign redirect_next = taken ? target : seq_pc;

    // -------------------------------------------------------------------------
    // Counter training
    // -------------------------------------------------------------------------
    always_comb begin
        ctr_next = ctr_cur;
        if (taken) begin
            if (ctr_cur != CTR_STRONG_T) begin
                ctr_next = ctr_cur + 2'b01;
            end
        end else begin
            if (ctr_cur != CTR_STRONG_NT) begin
                ctr_next = ctr_cur - 2'b01;
            end
        end
    end

    // One write-enable per entry; only the entry selected by the EX PC trains.
    generate
        for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht_we
            assign entry_we[gi] = accept & (ex_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_reg[i] <= CTR_WEAK_NT;
            end
        end else begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                if (entry_we[i]) begin
                    bht_reg[i] <= ctr_next;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered resolution
    // -------------------------------------------------------------------------
    logic            res_valid_reg;
    logic            res_taken_reg;
    logic            res_mispredict_reg;
    logic [XLEN-1:0] res_redirect_reg;
    logic            mispredict;

    assign mispredict = taken ^ pred_taken_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_reg      <= 1'b0;
            res_taken_reg      <= 1'b0;
            res_mispredict_reg <= 1'b0;
            res_redirect_reg   <= '0;
        end else begin
            res_valid_reg      <= accept;
            res_mispredict_reg <= accept & mispredict;
            // Outcome and redirect hold their last resolved values otherwise.
            if (accept) begin
                res_taken_reg    <= taken;
                res_redirect_reg <= redirect_next;
            end
        end
    end

    assign res_valid_o      = res_valid_reg;
    assign res_taken_o      = res_taken_reg;
    assign res_mispredict_o = res_mispredict_reg;
    assign res_redirect_o   = res_redirect_reg;

    // -------------------------------------------------------------------------
    // Performance counters, saturating at all-ones
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] br_cnt_reg;
    logic [CNT_W-1:0] br_cnt_next;
    logic [CNT_W-1:0] mis_cnt_reg;
    logic [CNT_W-1:0] mis_cnt_next;

    always_comb begin
        br_cnt_next  = br_cnt_reg;
        mis_cnt_next = mis_cnt_reg;
        if (accept && (br_cnt_reg != {CNT_W{1'b1}})) begin
            br_cnt_next = br_cnt_reg + CNT_W'(1);
        end
        if (accept && mispredict && (mis_cnt_reg != {CNT_W{1'b1}})) begin
            mis_cnt_next = mis_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_reg  <= '0;
            mis_cnt_reg <= '0;
        end else begin
            br_cnt_reg  <= br_cnt_next;
            mis_cnt_reg <= mis_cnt_next;
        end
    end

    assign br_cnt_o  = br_cnt_reg;
    assign mis_cnt_o = mis_cnt_reg;

endmodule

// File: tb/tb_ysyx_22040895_bru.sv
// -----------------------------------------------------------------------------
// Testbench for ysyx_22040895_bru.  Directed steps followed by random traffic,
// all checked against a behavioural model (integer counters per table slot,
// plain arithmetic for the compare, target and performance counters).
// -----------------------------------------------------------------------------
module tb_ysyx_22040895_bru;

    localparam int XLEN      = 64;
    localparam int BHT_DEPTH = 64;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_i;
    logic             flush_i;
    logic [2:0]       bcuop_i;
    logic [XLEN-1:0]  src1_i;
    logic [XLEN-1:0]  src2_i;
    logic [XLEN-1:0]  pc_i;
    logic [XLEN-1:0]  offset_i;
    logic             pred_taken_i;
    logic [XLEN-1:0]  fetch_pc_i;
    logic             fetch_pred_o;
    logic             res_valid_o;
    logic             res_taken_o;
    logic             res_mispredict_o;
    logic [XLEN-1:0]  res_redirect_o;
    logic [CNT_W-1:0] br_cnt_o;
    logic [CNT_W-1:0] mis_cnt_o;

    always #5 clk = ~clk;

    ysyx_22040895_bru #(
        .XLEN      (XLEN),
        .BHT_DEPTH (BHT_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_i          (valid_i),
        .flush_i          (flush_i),
        .bcuop_i          (bcuop_i),
        .src1_i           (src1_i),
        .src2_i           (src2_i),
        .pc_i             (pc_i),
        .offset_i         (offset_i),
        .pred_taken_i     (pred_taken_i),
        .fetch_pc_i       (fetch_pc_i),
        .fetch_pred_o     (fetch_pred_o),
        .res_valid_o      (res_valid_o),
        .res_taken_o      (res_taken_o),
        .res_mispredict_o (res_mispredict_o),
        .res_redirect_o   (res_redirect_o),
        .br_cnt_o         (br_cnt_o),
        .mis_cnt_o        (mis_cnt_o)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int          bht_m [BHT_DEPTH];
    int          br_m;
    int          mis_m;
    logic        rv_m;
    logic        rt_m;
    logic        rm_m;
    logic [63:0] rr_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_taken(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        longint sa;
        longint sb;
        sa = a;
        sb = b;
        case (op)
            3'd1: return a == b;
            3'd2: return sa >= sb;
            3'd3: return a >= b;
            3'd4: return sa < sb;
            3'd5: return a < b;
            3'd6: return a != b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx_of(input logic [63:0] pc);
        return int'((pc >> 2) % BHT_DEPTH);
    endfunction

    // One clock of stimulus: drive, check fetch prediction before the edge,
    // advance the model, then check the registered results after the edge.
    task automatic step(input logic r, input logic v, input logic f, input logic [2:0] op,
                        input logic [63:0] s1, input logic [63:0] s2,
                        input logic [63:0] pc, input logic [63:0] off,
                        input logic pred, input logic [63:0] fpc);
        logic acc;
        logic t;
        int   k;
        rst = r; valid_i = v; flush_i = f; bcuop_i = op;
        src1_i = s1; src2_i = s2; pc_i = pc; offset_i = off;
        pred_taken_i = pred; fetch_pc_i = fpc;
        #1;
        if (!r) check("fetch_pred", {63'd0, fetch_pred_o}, {63'd0, bht_m[idx_of(fpc)] >= 2});
        acc = v && !f && (op >= 3'd1) && (op <= 3'd6);
        if (r) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_m[i] = 1;
            br_m = 0; mis_m = 0; rv_m = 0; rt_m = 0; rm_m = 0; rr_m = 0;
        end else if (acc) begin
            t = ref_taken(op, s1, s2);
            rv_m = 1; rt_m = t; rm_m = (t != pred);
            rr_m = t ? (pc + off * 64'd2) : (pc + 64'd4);
            k = idx_of(pc);
            bht_m[k] = t ? ((bht_m[k] < 3) ? bht_m[k] + 1 : 3) : ((bht_m[k] > 0) ? bht_m[k] - 1 : 0);
            if (br_m < CNT_MAX) br_m++;
            if (t != pred && mis_m < CNT_MAX) mis_m++;
        end else begin
            rv_m = 0; rm_m = 0;
        end
        @(posedge clk);
        #1;
        $display("txn rst=%0b v=%0b f=%0b op=%0d pc=%h -> valid=%0b taken=%0b mis=%0b redir=%h br=%0d misc=%0d",
                 r, v, f, op, pc, res_valid_o, res_taken_o, res_mispredict_o, res_redirect_o,
                 br_cnt_o, mis_cnt_o);
        if (!r || !$isunknown(res_valid_o)) begin
            check("res_valid", {63'd0, res_valid_o}, {63'd0, rv_m});
            check("res_taken", {63'd0, res_taken_o}, {63'd0, rt_m});
            check("res_mispredict", {63'd0, res_mispredict_o}, {63'd0, rm_m});
            check("res_redirect", res_redirect_o, rr_m);
            check("br_cnt", {60'd0, br_cnt_o}, 64'(br_m));
            check("mis_cnt", {60'd0, mis_cnt_o}, 64'(mis_m));
        end
    endtask

    task automatic idle(input logic [63:0] fpc);
        step(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, fpc);
    endtask

    localparam logic [63:0] PC_T = 64'h8000_0100;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] pc;
        logic [63:0] fpc;
        logic [11:0] imm;
        int          br_before;

        for (int i = 0; i < BHT_DEPTH; i++) bht_m[i] = 1;
        rst = 1; valid_i = 0; flush_i = 0; bcuop_i = 0; src1_i = 0; src2_i = 0;
        pc_i = 0; offset_i = 0; pred_taken_i = 0; fetch_pc_i = 0;

        // Reset for two cycles, then sweep every table index
        step(1'b1, 1'b0, 1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 0);
        for (int i = 0; i < BHT_DEPTH; i++) begin
            idle(64'h8000_0000 + 64'(i * 4));
            check("reset_pred", {63'd0, fetch_pred_o}, 64'd0);
        end

        // Signed vs unsigned compare
        step(1'b0, 1'b1, 1'b0, 3'b100, ONES, 64'd1, 64'h8000_0000, 64'd8, 1'b0, 64'h0);
        check("blt_taken", {63'd0, res_taken_o}, 64'd1);
        check("blt_redirect", res_redirect_o, 64'h8000_0010);
        check("blt_mispredict", {63'd0, res_mispredict_o}, 64'd1);
        step(1'b0, 1'b1, 1'b0, 3'b101, ONES, 64'd1, 64'h8000_0000, 64'd8, 1'b0, 64'h0);
        check("bltu_taken", {63'd0, res_taken_o}, 64'd0);
        check("bltu_redirect", res_redirect_o, 64'h8000_0004);
        check("bltu_mispredict", {63'd0, res_mispredict_o}, 64'd0);

        // Counter training: 3 taken, then 3 not-taken
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 3'b001, 64'd5, 64'd5, PC_T, 64'd16, 1'b0, PC_T);
            idle(PC_T);
            check("train_taken_pred", {63'd0, fetch_pred_o}, 64'd1);
        end
        step(1'b0, 1'b1, 1'b0, 3'b001, 64'd5, 64'd6, PC_T, 64'd16, 1'b1, PC_T);
        idle(PC_T);
        check("train_weak_t_pred", {63'd0, fetch_pred_o}, 64'd1);
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b1, 1'b0, 3'b001, 64'd5, 64'd6, PC_T, 64'd16, 1'b1, PC_T);
        idle(PC_T);
        check("train_strong_nt_pred", {63'd0, fetch_pred_o}, 64'd0);

        // Bring counter to 01, then same-cycle lookup and update
        step(1'b0, 1'b1, 1'b0, 3'b001, 64'd5, 64'd5, PC_T, 64'd16, 1'b0, PC_T);
        step(1'b0, 1'b1, 1'b0, 3'b001, 64'd5, 64'd5, PC_T, 64'd16, 1'b0, PC_T);
        check("same_cycle_after", {63'd0, fetch_pred_o}, 64'd1);

        // Flush, illegal op, reset-over-accept
        br_before = br_m;
        step(1'b0, 1'b1, 1'b1, 3'b110, 64'd1, 64'd2, PC_T, 64'd16, 1'b0, PC_T);
        check("flush_valid", {63'd0, res_valid_o}, 64'd0);
        check("flush_br_cnt", {60'd0, br_cnt_o}, 64'(br_before));
        step(1'b0, 1'b1, 1'b0, 3'b111, 64'd1, 64'd2, PC_T, 64'd16, 1'b0, PC_T);
        check("illegal_valid", {63'd0, res_valid_o}, 64'd0);
        check("illegal_br_cnt", {60'd0, br_cnt_o}, 64'(br_before));
        step(1'b1, 1'b1, 1'b0, 3'b110, 64'd1, 64'd2, PC_T, 64'd16, 1'b0, PC_T);
        check("rst_accept_valid", {63'd0, res_valid_o}, 64'd0);
        check("rst_accept_redirect", res_redirect_o, 64'd0);
        check("rst_accept_br_cnt", {60'd0, br_cnt_o}, 64'd0);

        // Random traffic with index collisions
        for (int n = 0; n < 300; n++) begin
            a   = {$urandom, $urandom};
            b   = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b = {32'd0, $urandom_range(0, 8)};
            pc  = 64'h8000_0000 + 64'($urandom_range(0, 15) * 4);
            fpc = 64'h8000_0000 + 64'($urandom_range(0, 15) * 4);
            imm = 12'($urandom);
            step(1'b0, ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) == 0),
                 3'($urandom_range(0, 7)), a, b, pc, {{52{imm[11]}}, imm},
                 1'($urandom_range(0, 1)), fpc);
            if ($urandom_range(0, 49) == 0) idle(fpc);
        end

        // Counter saturation, then target wrap-around
        step(1'b1, 1'b0, 1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 0);
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b1, 1'b0, 3'b001, 64'd7, 64'd7, PC_T, 64'd16, 1'b0, PC_T);
        check("sat_br_cnt", {60'd0, br_cnt_o}, 64'd15);
        check("sat_mis_cnt", {60'd0, mis_cnt_o}, 64'd15);
        step(1'b0, 1'b1, 1'b0, 3'b001, 64'd7, 64'd7, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 1'b1, PC_T);
        check("wrap_redirect", res_redirect_o, 64'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ysyx_22040895_bru.md
Name: ysyx_22040895_bru

Overview:
- Parametrised branch resolution unit, successor to the combinational branch compare unit.
- Performs its own signed and unsigned compares on full operands, and computes the target as pc + (offset << 1).
- Keeps a direct-mapped bimodal history table (BHT) of 2-bit counters, used for fetch-stage prediction and trained on resolution.
- Registers the resolution with one-cycle latency, raises a mispredict redirect to the EX/IF boundary, and keeps saturating performance counters.

Parameters:
- XLEN, 64, operand/PC width.
- BHT_DEPTH, 64, number of BHT entries; power of two, >= 2.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- valid_i  in  1  branch instruction present in EX this cycle.
- flush_i  in  1  kill the EX instruction this cycle.
- bcuop_i  in  3  001 beq, 010 bge, 011 bgeu, 100 blt, 101 bltu, 110 bne; 000/111 = not a branch.
- src1_i  in  XLEN  rs1 value.
- src2_i  in  XLEN  rs2 value.
- pc_i  in  XLEN  branch PC.
- offset_i  in  XLEN  sign-extended imm[12:1].
- pred_taken_i  in  1  prediction carried down from fetch.
- fetch_pc_i  in  XLEN  fetch PC for lookup.
- fetch_pred_o  out  1  predicted taken for fetch_pc_i.
- res_valid_o  out  1  resolution valid.
- res_taken_o  out  1  actual outcome.
- res_mispredict_o  out  1  res_taken_o != predicted.
- res_redirect_o  out  XLEN  correct next PC.
- br_cnt_o  out  CNT_W  resolved branch count.
- mis_cnt_o  out  CNT_W  mispredict count.

Behaviour:
- BHT index = pc[$clog2(BHT_DEPTH)+1:2].
- fetch_pred_o = bht[idx(fetch_pc_i)][1]. Combinational read; reflects the table state before any same-cycle update (read-before-write).
- Compares, all XLEN wide:
  - eq = (src1 == src2).
  - lt is signed.
  - ltu is unsigned.
  - Taken conditions as in the bcuop encoding: bge = ~lt, bgeu = ~ltu, bne = ~eq.
- Target = pc_i + (offset_i << 1), modulo 2^XLEN; wrap-around is not flagged.
- Accept condition: valid_i & ~flush_i & legal bcuop.
- On an accepted cycle, at the next clk edge:
  - res_valid_o = 1.
  - res_taken_o = taken.
  - res_mispredict_o = taken ^ pred_taken_i.
  - res_redirect_o = taken ? target : pc_i + 4.
- If not accepted: res_valid_o = 0 and res_mispredict_o = 0. res_taken_o and res_redirect_o hold their previous values.
- Illegal op (000/111) with valid_i: ignored. No output, no BHT update, no count.
- BHT update on an accepted cycle, 2-bit saturating counter:
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
  - States: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Back-to-back branches with the same index: the second branch sees the first branch's updated counter. No bypass on pred_taken_i; prediction is fetch-time only.
- Counters:
  - br_cnt increments on every accepted cycle.
  - mis_cnt increments when the accepted branch mispredicts.
  - Both saturate at all-ones and do not wrap.
- Reset (sync, rst high at an edge):
  - All BHT entries = 01.
  - res_valid_o = 0, res_taken_o = 0, res_mispredict_o = 0, res_redirect_o = 0.
  - br_cnt_o = 0, mis_cnt_o = 0.
- Reset overrides an accepted branch in the same cycle: no update, no output.
- flush_i has priority over valid_i. A flush is a full kill: no state changes.
- Throughput: one branch per cycle, no stalls, no backpressure.

Test Plan:
- Reset then read: rst for 2 cycles, sweep fetch_pc_i across all BHT_DEPTH indices -> fetch_pred_o = 0 everywhere; all outputs and counters = 0.
- Signed vs unsigned compare: src1 = 0xFFFF_FFFF_FFFF_FFFF, src2 = 1, pc = 0x8000_0000, offset = 8, pred = 0.
  - blt -> next cycle taken = 1, redirect = 0x8000_0010, mispredict = 1.
  - bltu -> taken = 0, redirect = 0x8000_0004, mispredict = 0.
- Counter training on pc = 0x8000_0100:
  - Three taken beq -> counter 01→10→11→11; fetch_pred_o = 1 after the first.
  - One not-taken -> 10, prediction still 1.
  - Two more not-taken -> 00.
- Same-cycle lookup/update: fetch_pc_i = pc_i = 0x8000_0100 with counter at 01, taken branch accepted -> fetch_pred_o = 0 that cycle and 1 the next.
- Flush and illegal op:
  - valid = 1, flush = 1, bne taken -> res_valid_o = 0, BHT and br_cnt unchanged.
  - bcuop = 111 with valid = 1 -> same result.
  - rst asserted with an accepted branch -> outputs 0.
- Counter saturation and wrap: with CNT_W = 4, 20 mispredicting branches -> br_cnt = mis_cnt = 15. pc = 0xFFFF_FFFF_FFFF_FFF0, offset = 0x10 -> target wraps to 0x10.
